// File: rtl/aec_pkg.sv
// Shared definitions for the arithmetic-expression-calculator transmit driver:
// token codes, ASCII constants, FSM state encoding and default buffer depth.
package aec_pkg;

    localparam int MAX_TOK_DEF = 15;

    localparam logic [4:0] TOK_HEX_MAX = 5'd15;
    localparam logic [4:0] TOK_LPAREN  = 5'd16;
    localparam logic [4:0] TOK_RPAREN  = 5'd17;
    localparam logic [4:0] TOK_MUL     = 5'd18;
    localparam logic [4:0] TOK_PLUS    = 5'd19;
    localparam logic [4:0] TOK_MINUS   = 5'd20;

    localparam logic [7:0] ASCII_NUL    = 8'h00;
    localparam logic [7:0] ASCII_LPAREN = 8'h28;
    localparam logic [7:0] ASCII_RPAREN = 8'h29;
    localparam logic [7:0] ASCII_MUL    = 8'h2A;
    localparam logic [7:0] ASCII_PLUS   = 8'h2B;
    localparam logic [7:0] ASCII_MINUS  = 8'h2D;
    localparam logic [7:0] ASCII_EQ     = 8'h3D;
    localparam logic [7:0] ASCII_0      = 8'h30;
    localparam logic [7:0] ASCII_A      = 8'h61;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_TERM,
        ST_WAIT,
        ST_DONE,
        ST_GUARD
    } aec_state_t;

endpackage

// File: rtl/aec_tok2ascii.sv
// Combinational mapper from a 5-bit expression token code to its ASCII character.
// Codes outside the token set map to NUL.
module aec_tok2ascii
    import aec_pkg::*;
(
    input  logic [4:0] tok,
    output logic [7:0] ascii
);

    always_comb begin
        ascii = ASCII_NUL;
        if (tok <= 5'd9) begin
            ascii = ASCII_0 + {3'b000, tok};
        end else if (tok <= TOK_HEX_MAX) begin
            ascii = ASCII_A + {3'b000, tok - 5'd10};
        end else begin
            case (tok)
                TOK_LPAREN: ascii = ASCII_LPAREN;
                TOK_RPAREN: ascii = ASCII_RPAREN;
                TOK_MUL:    ascii = ASCII_MUL;
                TOK_PLUS:   ascii = ASCII_PLUS;
                TOK_MINUS:  ascii = ASCII_MINUS;
                default:    ascii = ASCII_NUL;
            endcase
        end
    end

endmodule

// File: rtl/aec_expr_tx.sv
// Transmit-side driver: buffers tokens, streams them as ASCII terminated by '=',
// then captures the calculator response. Optional WAIT timeout: AEC_TX_TIMEOUT_EN.
module aec_expr_tx
    import aec_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255,
    parameter int MAX_TOK = MAX_TOK_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tok_wr,
    input  logic [4:0] tok_data,
    output logic       tok_full,
    input  logic       start,
    output logic       busy,
    output logic [7:0] ascii_out,
    output logic       ready_out,
    input  logic       aec_valid,
    input  logic [6:0] aec_result,
    input  logic       aec_legal,
    output logic       res_valid,
    output logic [6:0] res_value,
    output logic       res_legal
`ifdef AEC_TX_TIMEOUT_EN
    ,
    output logic       res_timeout
`endif
);

    localparam int CW = $clog2(MAX_TOK + 1);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_TOK);
    localparam logic [CW-1:0] ONE_C = CW'(1);

    aec_state_t      state, state_nxt;
    logic [CW-1:0]   count, count_nxt;
    logic [CW-1:0]   ptr, ptr_nxt;
    logic [4:0]      tok_buf [MAX_TOK];
    logic            wr_en;
    logic            cap_en;
    logic [6:0]      cap_value;
    logic            cap_legal;
    logic [7:0]      tok_ascii;

`ifdef AEC_TX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
    logic [TW-1:0] to_cnt;
    logic          to_hit;
    logic          to_flag;
`endif

    aec_tok2ascii u_map (
        .tok   (tok_buf[ptr]),
        .ascii (tok_ascii)
    );

    assign tok_full = (count == MAX_C);

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        ptr_nxt   = ptr;
        wr_en     = 1'b0;
        cap_en    = 1'b0;
        cap_value = aec_result;
        cap_legal = aec_legal;
        busy      = 1'b1;
        ascii_out = ASCII_NUL;
        ready_out = 1'b0;
        res_valid = 1'b0;
`ifdef AEC_TX_TIMEOUT_EN
        to_hit    = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (tok_wr && tok_data <= TOK_MINUS && count < MAX_C) begin
                    wr_en     = 1'b1;
                    count_nxt = count + ONE_C;
                end
                // A token written alongside start is already counted here.
                if (start && count_nxt != '0) begin
                    state_nxt = ST_SEND;
                    ptr_nxt   = '0;
                end
            end
            ST_SEND: begin
                ascii_out = tok_ascii;
                ready_out = (ptr == '0);
                if (ptr == count - ONE_C) begin
                    state_nxt = ST_TERM;
                end else begin
                    ptr_nxt = ptr + ONE_C;
                end
            end
            ST_TERM: begin
                ascii_out = ASCII_EQ;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (aec_valid) begin
                    cap_en    = 1'b1;
                    state_nxt = ST_DONE;
                end
`ifdef AEC_TX_TIMEOUT_EN
                else if (to_cnt == TO_LAST) begin
                    cap_en    = 1'b1;
                    cap_value = '0;
                    cap_legal = 1'b0;
                    to_hit    = 1'b1;
                    state_nxt = ST_DONE;
                end
`endif
            end
            ST_DONE: begin
                res_valid = 1'b1;
                count_nxt = '0;
                ptr_nxt   = '0;
                state_nxt = ST_GUARD;
            end
            ST_GUARD: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

`ifdef AEC_TX_TIMEOUT_EN
    always_comb begin
        res_timeout = 1'b0;
        if (state == ST_DONE) begin
            res_timeout = to_flag;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            count     <= '0;
            ptr       <= '0;
            res_value <= '0;
            res_legal <= 1'b0;
`ifdef AEC_TX_TIMEOUT_EN
            to_cnt    <= '0;
            to_flag   <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            ptr   <= ptr_nxt;
            if (cap_en) begin
                res_value <= cap_value;
                res_legal <= cap_legal;
            end
`ifdef AEC_TX_TIMEOUT_EN
            if (state == ST_WAIT) begin
                to_cnt <= to_cnt + 1'b1;
            end else begin
                to_cnt <= '0;
            end
            if (cap_en) begin
                to_flag <= to_hit;
            end
`endif
        end
    end

    // Token storage carries no reset; count gates which entries are meaningful.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tok_buf[count] <= tok_data;
        end
    end

endmodule
